// File: rtl/if_fetch_unit_if.sv
// Signal bundle between the instruction-fetch stage, the instruction memory and decode.
// Handshake: the queue head moves to decode on a rising edge where IF_valid=1, ID_stall=0 and
// JumpPC=0 (ID_stall is an inverted ready, ignored while IF_valid=0); imem_req is a
// request-only read strobe whose data is on imem_rdata in the following cycle.
interface if_fetch_unit_if #(
    parameter int AW    = 8,
    parameter int IW    = 8,
    parameter int DEPTH = 2
);
    logic                         JumpPC;
    logic [AW-1:0]                jump_target;
    logic                         ID_stall;
    logic                         imem_req;
    logic [AW-1:0]                imem_addr;
    logic [IW-1:0]                imem_rdata;
    logic [IW-1:0]                IF_instr;
    logic [AW-1:0]                IF_PC_next;
    logic                         IF_valid;
    logic [$clog2(DEPTH+1)-1:0]   dbg_count;
    logic                         dbg_inflight;

    modport master (
        input  JumpPC, jump_target, ID_stall, imem_rdata,
        output imem_req, imem_addr, IF_instr, IF_PC_next, IF_valid, dbg_count, dbg_inflight
    );

    modport slave (
        output JumpPC, jump_target, ID_stall, imem_rdata,
        input  imem_req, imem_addr, IF_instr, IF_PC_next, IF_valid, dbg_count, dbg_inflight
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads a synchronous instruction memory and
// buffers {instr, PC+1} pairs in a small FIFO that feeds the IF/ID register.
module if_fetch_unit #(
    parameter int            AW       = 8,
    parameter int            IW       = 8,
    parameter int            DEPTH    = 2,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter logic [IW-1:0] NOP      = '0
) (
    input  logic          clk,
    input  logic          rst,
    if_fetch_unit_if.master bus
);
    localparam int            PW      = $clog2(DEPTH);
    localparam int            CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);

    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] pend_pc_q, pend_pc_d;
    logic          inflight_q, inflight_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [IW-1:0] q_instr_q [DEPTH];
    logic [IW-1:0] q_instr_d [DEPTH];
    logic [AW-1:0] q_pc_q    [DEPTH];
    logic [AW-1:0] q_pc_d    [DEPTH];

    logic          head_valid;
    logic          pop;
    logic          push;
    logic          issue;
    logic [CW:0]   occupancy;

    // Occupancy counts the slot already promised to the in-flight read, so a
    // response always has room and is never dropped except by a redirect.
    always_comb begin
        head_valid = (count_q != '0);
        pop        = head_valid & ~bus.ID_stall & ~bus.JumpPC;
        push       = inflight_q & ~bus.JumpPC;
        occupancy  = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
        issue      = rst & ~bus.JumpPC & (occupancy < DEPTH_W);
    end

    always_comb begin
        pc_d       = pc_q;
        pend_pc_d  = pend_pc_q;
        inflight_d = issue;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        q_instr_d  = q_instr_q;
        q_pc_d     = q_pc_q;
        if (bus.JumpPC) begin
            pc_d     = bus.jump_target;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (issue) begin
                pc_d      = pc_q + AW'(1);
                pend_pc_d = pc_q + AW'(1);
            end
            if (push) begin
                q_instr_d[wr_ptr_q] = bus.imem_rdata;
                q_pc_d[wr_ptr_q]    = pend_pc_q;
                wr_ptr_d            = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= RESET_PC;
            pend_pc_q  <= '0;
            inflight_q <= 1'b0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_instr_q[i] <= NOP;
                q_pc_q[i]    <= '0;
            end
        end else begin
            pc_q       <= pc_d;
            pend_pc_q  <= pend_pc_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            q_instr_q  <= q_instr_d;
            q_pc_q     <= q_pc_d;
        end
    end

    assign bus.imem_req     = issue;
    assign bus.imem_addr    = pc_q;
    assign bus.IF_valid     = head_valid;
    assign bus.IF_instr     = head_valid ? q_instr_q[rd_ptr_q] : NOP;
    assign bus.IF_PC_next   = head_valid ? q_pc_q[rd_ptr_q] : '0;
    assign bus.dbg_count    = count_q;
    assign bus.dbg_inflight = inflight_q;
endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed fill/stall/redirect/reset scenarios
// followed by a randomized stall/redirect run against a PC-stream model.
module tb_if_fetch_unit;
  localparam int AW = 8;
  localparam int IW = 8;
  localparam int DEPTH = 2;
  localparam logic [1:0] DEPTH_C = 2'd2;
  localparam logic [7:0] NOP_C = 8'h00;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [7:0] rom [256];
  logic [7:0] exp_head;
  logic [7:0] exp_q[$];

  if_fetch_unit_if #(.AW(AW), .IW(IW), .DEPTH(DEPTH)) bus ();

  if_fetch_unit #(
    .AW(AW), .IW(IW), .DEPTH(DEPTH), .RESET_PC(8'h00), .NOP(8'h00)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // synchronous instruction memory: data for a request appears in the next cycle
  always @(posedge clk) begin
    if (bus.imem_req === 1'b1) bus.imem_rdata <= rom[bus.imem_addr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic j, input logic [7:0] t, input logic s);
    bus.JumpPC = j;
    bus.jump_target = t;
    bus.ID_stall = s;
  endtask

  task automatic test_reset();
    set_in(1'b0, 8'h00, 1'b0);
    #2 rst = 1'b0;
    repeat (2) next_cycle();
    @(negedge clk);
    checks++; if (bus.IF_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.IF_valid); end
    checks++; if (bus.IF_instr !== NOP_C) begin errors++; $display("FAIL reset_instr: got %h want %h", bus.IF_instr, NOP_C); end
    checks++; if (bus.IF_PC_next !== 8'h00) begin errors++; $display("FAIL reset_pcnext: got %h want 00", bus.IF_PC_next); end
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", bus.imem_req); end
    checks++; if (bus.dbg_count !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.dbg_count); end
    next_cycle();
  endtask

  task automatic test_fill();
    logic [7:0] e_pc;
    logic [7:0] e_ins;
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      e_pc = 8'(c - 1);
      e_ins = 8'h10 + 8'(c - 2);
      checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL fill_req c=%0d: got %b want 1", c, bus.imem_req); end
      checks++; if (bus.imem_addr !== 8'(c)) begin errors++; $display("FAIL fill_addr c=%0d: got %h want %h", c, bus.imem_addr, 8'(c)); end
      checks++; if (bus.IF_valid !== (c >= 2)) begin errors++; $display("FAIL fill_valid c=%0d: got %b want %b", c, bus.IF_valid, (c >= 2)); end
      if (c >= 2) begin
        checks++; if (bus.IF_PC_next !== e_pc) begin errors++; $display("FAIL fill_pcnext c=%0d: got %h want %h", c, bus.IF_PC_next, e_pc); end
        checks++; if (bus.IF_instr !== e_ins) begin errors++; $display("FAIL fill_instr c=%0d: got %h want %h", c, bus.IF_instr, e_ins); end
      end else begin
        checks++; if (bus.IF_instr !== NOP_C) begin errors++; $display("FAIL fill_nop c=%0d: got %h want %h", c, bus.IF_instr, NOP_C); end
      end
      next_cycle();
    end
    exp_head = 8'h05;
  endtask

  task automatic test_stall();
    logic [7:0] e_ins;
    set_in(1'b0, 8'h00, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      e_ins = rom[exp_head - 8'd1];
      checks++; if (bus.IF_valid !== 1'b1) begin errors++; $display("FAIL stall_valid c=%0d: got %b want 1", c, bus.IF_valid); end
      checks++; if (bus.IF_PC_next !== exp_head) begin errors++; $display("FAIL stall_hold c=%0d: got %h want %h", c, bus.IF_PC_next, exp_head); end
      checks++; if (bus.IF_instr !== e_ins) begin errors++; $display("FAIL stall_instr c=%0d: got %h want %h", c, bus.IF_instr, e_ins); end
      checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL stall_req c=%0d: got %b want 0", c, bus.imem_req); end
      if (c >= 1) begin
        checks++; if (bus.dbg_count !== DEPTH_C) begin errors++; $display("FAIL stall_count c=%0d: got %0d want %0d", c, bus.dbg_count, DEPTH_C); end
      end
      next_cycle();
    end
    set_in(1'b0, 8'h00, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      e_ins = rom[exp_head - 8'd1];
      checks++; if (bus.IF_valid !== 1'b1) begin errors++; $display("FAIL resume_valid c=%0d: got %b want 1", c, bus.IF_valid); end
      checks++; if (bus.IF_PC_next !== exp_head) begin errors++; $display("FAIL resume_pcnext c=%0d: got %h want %h", c, bus.IF_PC_next, exp_head); end
      checks++; if (bus.IF_instr !== e_ins) begin errors++; $display("FAIL resume_instr c=%0d: got %h want %h", c, bus.IF_instr, e_ins); end
      checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL resume_req c=%0d: got %b want 1", c, bus.imem_req); end
      exp_head = exp_head + 8'd1;
      next_cycle();
    end
  endtask

  // redirect to tgt; pre_stall>0 first fills the queue and keeps ID_stall high with JumpPC
  task automatic test_jump(input logic [7:0] tgt, input int pre_stall);
    logic [7:0] e_addr;
    logic [7:0] e_pc;
    logic [7:0] e_ins;
    if (pre_stall > 0) begin
      set_in(1'b0, 8'h00, 1'b1);
      repeat (pre_stall) next_cycle();
    end
    set_in(1'b1, tgt, (pre_stall > 0));
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL jump_req_%h: got %b want 0", tgt, bus.imem_req); end
    checks++; if (bus.IF_valid !== 1'b1) begin errors++; $display("FAIL jump_prevalid_%h: got %b want 1", tgt, bus.IF_valid); end
    if (pre_stall >= 2) begin
      checks++; if (bus.dbg_count !== DEPTH_C) begin errors++; $display("FAIL jump_full_%h: got %0d want %0d", tgt, bus.dbg_count, DEPTH_C); end
    end
    next_cycle();
    set_in(1'b0, 8'h00, 1'b0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      e_addr = tgt + 8'(c);
      e_pc = tgt + 8'(c - 1);
      e_ins = rom[tgt + 8'(c - 2)];
      checks++; if (bus.imem_addr !== e_addr) begin errors++; $display("FAIL jump_addr_%h c=%0d: got %h want %h", tgt, c, bus.imem_addr, e_addr); end
      checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL jump_issue_%h c=%0d: got %b want 1", tgt, c, bus.imem_req); end
      checks++; if (bus.IF_valid !== (c >= 2)) begin errors++; $display("FAIL jump_valid_%h c=%0d: got %b want %b", tgt, c, bus.IF_valid, (c >= 2)); end
      if (c >= 2) begin
        checks++; if (bus.IF_PC_next !== e_pc) begin errors++; $display("FAIL jump_pcnext_%h c=%0d: got %h want %h", tgt, c, bus.IF_PC_next, e_pc); end
        checks++; if (bus.IF_instr !== e_ins) begin errors++; $display("FAIL jump_instr_%h c=%0d: got %h want %h", tgt, c, bus.IF_instr, e_ins); end
      end
      next_cycle();
    end
    exp_head = tgt + 8'd5;
  endtask

  task automatic test_hold_jump();
    logic [7:0] tg [3];
    logic [7:0] e_pc;
    tg[0] = 8'h20; tg[1] = 8'h30; tg[2] = 8'h60;
    for (int k = 0; k < 3; k++) begin
      set_in(1'b1, tg[k], 1'b0);
      @(negedge clk);
      checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL hold_req k=%0d: got %b want 0", k, bus.imem_req); end
      if (k >= 1) begin
        checks++; if (bus.IF_valid !== 1'b0) begin errors++; $display("FAIL hold_valid k=%0d: got %b want 0", k, bus.IF_valid); end
      end
      next_cycle();
    end
    set_in(1'b0, 8'h00, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      e_pc = 8'h60 + 8'(c - 1);
      if (c == 0) begin
        checks++; if (bus.imem_addr !== 8'h60) begin errors++; $display("FAIL hold_addr: got %h want 60", bus.imem_addr); end
      end
      checks++; if (bus.IF_valid !== (c >= 2)) begin errors++; $display("FAIL hold_out_valid c=%0d: got %b want %b", c, bus.IF_valid, (c >= 2)); end
      if (c >= 2) begin
        checks++; if (bus.IF_PC_next !== e_pc) begin errors++; $display("FAIL hold_pcnext c=%0d: got %h want %h", c, bus.IF_PC_next, e_pc); end
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] e_pc;
    set_in(1'b0, 8'h00, 1'b1);
    repeat (2) next_cycle();
    @(negedge clk);
    checks++; if (bus.dbg_count !== DEPTH_C) begin errors++; $display("FAIL rmid_full: got %0d want %0d", bus.dbg_count, DEPTH_C); end
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    checks++; if (bus.IF_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", bus.IF_valid); end
    checks++; if (bus.IF_instr !== NOP_C) begin errors++; $display("FAIL rmid_instr: got %h want %h", bus.IF_instr, NOP_C); end
    checks++; if (bus.IF_PC_next !== 8'h00) begin errors++; $display("FAIL rmid_pcnext: got %h want 00", bus.IF_PC_next); end
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rmid_req: got %b want 0", bus.imem_req); end
    checks++; if (bus.dbg_count !== 2'd0) begin errors++; $display("FAIL rmid_count: got %0d want 0", bus.dbg_count); end
    set_in(1'b0, 8'h00, 1'b0);
    repeat (2) next_cycle();
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      e_pc = 8'(c - 1);
      checks++; if (bus.imem_addr !== 8'(c)) begin errors++; $display("FAIL rmid_addr c=%0d: got %h want %h", c, bus.imem_addr, 8'(c)); end
      checks++; if (bus.IF_valid !== (c >= 2)) begin errors++; $display("FAIL rmid_restart_valid c=%0d: got %b want %b", c, bus.IF_valid, (c >= 2)); end
      if (c >= 2) begin
        checks++; if (bus.IF_PC_next !== e_pc) begin errors++; $display("FAIL rmid_restart_pc c=%0d: got %h want %h", c, bus.IF_PC_next, e_pc); end
      end
      next_cycle();
    end
  endtask

  // model: after a redirect (or reset) the head is empty for two cycles, then every
  // cycle presents the next PC of the stream; pops walk the stream in order
  task automatic test_random();
    logic j, s, primed;
    logic [7:0] t, last_tgt, e_ins, e_idx, tail;
    int warm, pops;
    primed = 1'b0; warm = 0; pops = 0; last_tgt = 8'h00;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      j = (cyc == 0) || ($urandom_range(0, 31) == 0);
      s = 1'($urandom_range(0, 1));
      t = 8'($urandom_range(0, 255));
      set_in(j, t, s);
      @(negedge clk);
      if (primed) begin
        checks++; if (bus.IF_valid !== (warm == 2)) begin errors++; $display("FAIL rand_valid cyc=%0d: got %b want %b", cyc, bus.IF_valid, (warm == 2)); end
        if (warm == 2) begin
          e_idx = exp_q[0] - 8'd1;
          e_ins = rom[e_idx];
          checks++; if (bus.IF_PC_next !== exp_q[0]) begin errors++; $display("FAIL rand_pcnext cyc=%0d: got %h want %h", cyc, bus.IF_PC_next, exp_q[0]); end
          checks++; if (bus.IF_instr !== e_ins) begin errors++; $display("FAIL rand_instr cyc=%0d: got %h want %h", cyc, bus.IF_instr, e_ins); end
        end else begin
          checks++; if (bus.IF_PC_next !== 8'h00 || bus.IF_instr !== NOP_C) begin errors++; $display("FAIL rand_idle cyc=%0d: got %h/%h want 00/%h", cyc, bus.IF_PC_next, bus.IF_instr, NOP_C); end
        end
        if (warm == 0 && !j) begin
          checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== last_tgt) begin errors++; $display("FAIL rand_first_req cyc=%0d: got %b/%h want 1/%h", cyc, bus.imem_req, bus.imem_addr, last_tgt); end
        end
      end
      if (j) begin
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rand_jump_req cyc=%0d: got %b want 0", cyc, bus.imem_req); end
      end
      checks++; if (bus.dbg_count > DEPTH_C) begin errors++; $display("FAIL rand_count cyc=%0d: got %0d want <= %0d", cyc, bus.dbg_count, DEPTH_C); end
      if (j) begin
        exp_q.delete();
        for (int k = 1; k <= 4; k++) exp_q.push_back(t + 8'(k));
        warm = 0; last_tgt = t; primed = 1'b1;
      end else if (primed) begin
        if (warm == 2 && !s) begin
          tail = exp_q[$] + 8'd1;
          void'(exp_q.pop_front());
          exp_q.push_back(tail);
          pops++;
        end
        if (warm < 2) warm++;
      end
      next_cycle();
    end
    set_in(1'b0, 8'h00, 1'b0);
    checks++; if (pops < 200) begin errors++; $display("FAIL rand_throughput: got %0d pops want >= 200", pops); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'(i) + 8'h10;
    test_reset();
    test_fill();
    test_stall();
    test_jump(8'h40, 0);
    test_jump(8'hFE, 0);
    test_jump(8'h80, 2);
    test_hold_jump();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
